btb_update_sched: RTL and testbench

//   Schedules writes into the branch target buffer. Accepts resolved-taken updates from two

---
 rtl/btb_update_sched_pkg.sv | 19 +
 rtl/btb_update_sched_btbq_fifo.sv | 103 ++++++++++
 rtl/btb_update_sched.sv | 173 +++++++++++++++++
 tb/tb_btb_update_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_update_sched_pkg.sv
// Shared definitions for the BTB update scheduler.
//   DEFAULT_XLEN  : address/target width
//   DEFAULT_DEPTH : update queue entries (power of two, >= 2)
//   rr_sel_e      : which requester wins a tie / is enqueued first
package btb_update_sched_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic {
    RR_BR  = 1'b0,
    RR_JMP = 1'b1
  } rr_sel_e;

  function automatic rr_sel_e rr_flip(input rr_sel_e cur);
    return (cur == RR_BR) ? RR_JMP : RR_BR;
  endfunction

endpackage

// File: rtl/btb_update_sched_btbq_fifo.sv
// Update queue for the BTB scheduler: pc/target storage, wrap-around pointers
// and occupancy count.
//   push_cnt / push0_* / push1_* : up to two new entries per cycle, push0 first
//   tail_wr / tail_target        : rewrite the target of the newest entry
//   pop                          : retire the head entry
//   flush                        : empty the queue at the next edge
//   head_pc / head_target        : oldest entry
//   tail_pc                      : pc of the newest entry (merge compare)
//   pending                      : entries currently queued
module btbq_fifo
  import btb_update_sched_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   pop,
  input  logic [1:0]             push_cnt,
  input  logic [XLEN-1:0]        push0_pc,
  input  logic [XLEN-1:0]        push0_target,
  input  logic [XLEN-1:0]        push1_pc,
  input  logic [XLEN-1:0]        push1_target,
  input  logic                   tail_wr,
  input  logic [XLEN-1:0]        tail_target,
  output logic [XLEN-1:0]        head_pc,
  output logic [XLEN-1:0]        head_target,
  output logic [XLEN-1:0]        tail_pc,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [XLEN-1:0] pc_mem     [DEPTH];
  logic [XLEN-1:0] target_mem [DEPTH];
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   wr_ptr_p1;
  logic [AW-1:0]   tail_ptr;
  logic [PW-1:0]   pending_reg;
  logic [DEPTH-1:0] we0;
  logic [DEPTH-1:0] we1;
  logic [DEPTH-1:0] wt;

  assign wr_ptr_p1 = wr_ptr_reg + AW'(1);
  assign tail_ptr  = wr_ptr_reg - AW'(1);

  // Per-entry write enables. A tail rewrite never collides with a push slot:
  // a rewrite needs pending >= 1, which limits the pushes to free slots only.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry_we
      assign we0[gi] = (push_cnt != 2'd0) && (wr_ptr_reg == AW'(gi));
      assign we1[gi] = (push_cnt == 2'd2) && (wr_ptr_p1  == AW'(gi));
      assign wt[gi]  = tail_wr && (tail_ptr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]     <= '0;
        target_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we0[i]) begin
          pc_mem[i]     <= push0_pc;
          target_mem[i] <= push0_target;
        end else if (we1[i]) begin
          pc_mem[i]     <= push1_pc;
          target_mem[i] <= push1_target;
        end else if (wt[i]) begin
          target_mem[i] <= tail_target;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      pending_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      pending_reg <= '0;
    end else begin
      rd_ptr_reg  <= rd_ptr_reg + AW'(pop);
      wr_ptr_reg  <= wr_ptr_reg + AW'(push_cnt);
      pending_reg <= pending_reg + PW'(push_cnt) - PW'(pop);
    end
  end

  assign head_pc     = pc_mem[rd_ptr_reg];
  assign head_target = target_mem[rd_ptr_reg];
  assign tail_pc     = pc_mem[tail_ptr];
  assign pending     = pending_reg;

endmodule

// File: rtl/btb_update_sched.sv
// BTB update scheduler: round-robin arbitration between the EX branch unit and
// the ID jump decoder, merging of repeated updates to the same pc, and a
// one-per-cycle drain onto the BTB write port.
//   br_* / jmp_*  : valid/ready update requests (pc, target)
//   hold          : stop draining, keep accepting
//   flush_q       : drop everything queued, block new requests this cycle
//   btb_*         : registered one-cycle write strobe with pc/target
//   pending       : queued entry count
module btb_update_sched
  import btb_update_sched_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   br_valid,
  input  logic [XLEN-1:0]        br_pc,
  input  logic [XLEN-1:0]        br_target,
  output logic                   br_ready,
  input  logic                   jmp_valid,
  input  logic [XLEN-1:0]        jmp_pc,
  input  logic [XLEN-1:0]        jmp_target,
  output logic                   jmp_ready,
  input  logic                   hold,
  input  logic                   flush_q,
  output logic                   btb_update_enable,
  output logic [XLEN-1:0]        btb_pc_update,
  output logic [XLEN-1:0]        btb_target_update,
  output logic                   btb_is_branch_or_jump,
  output logic [$clog2(DEPTH):0] pending
);

  localparam int PW = $clog2(DEPTH) + 1;

  rr_sel_e         rr_reg, rr_next;
  logic [PW-1:0]   free;
  logic            fav_is_br;
  logic            br_acc, jmp_acc;
  logic            first_vld, second_vld;
  logic [XLEN-1:0] a_pc, a_tgt, b_pc, b_tgt;
  logic            pop, can_merge, a_merge, b_merge_a;
  logic [1:0]      push_cnt;
  logic [XLEN-1:0] push0_pc, push0_target, push1_pc, push1_target;
  logic            tail_wr;
  logic [XLEN-1:0] tail_target;
  logic [XLEN-1:0] head_pc, head_target, tail_pc;
  logic            upd_en_reg;
  logic [XLEN-1:0] upd_pc_reg, upd_tgt_reg;

  assign free      = PW'(DEPTH) - pending;
  assign fav_is_br = (rr_reg == RR_BR);

  // With a single free slot the favoured requester gets it if it is asking;
  // otherwise the slot is offered to the other side.
  always_comb begin
    br_ready  = 1'b0;
    jmp_ready = 1'b0;
    if (!flush_q) begin
      if (free >= PW'(2)) begin
        br_ready  = 1'b1;
        jmp_ready = 1'b1;
      end else if (free == PW'(1)) begin
        if (fav_is_br) begin
          if (br_valid) br_ready = 1'b1;
          else          jmp_ready = 1'b1;
        end else begin
          if (jmp_valid) jmp_ready = 1'b1;
          else           br_ready = 1'b1;
        end
      end
    end
  end

  assign br_acc     = br_valid && br_ready;
  assign jmp_acc    = jmp_valid && jmp_ready;
  assign first_vld  = br_acc || jmp_acc;
  assign second_vld = br_acc && jmp_acc;

  // 'a' is the request enqueued first, 'b' the second (only when both accepted).
  always_comb begin
    a_pc  = br_pc;
    a_tgt = br_target;
    b_pc  = jmp_pc;
    b_tgt = jmp_target;
    if ((second_vld && !fav_is_br) || (!br_acc && jmp_acc)) begin
      a_pc  = jmp_pc;
      a_tgt = jmp_target;
      b_pc  = br_pc;
      b_tgt = br_target;
    end
  end

  assign pop = (pending != '0) && !hold && !flush_q;

  // The newest entry can't absorb a merge if it is the head leaving this edge.
  assign can_merge = (pending != '0) && !(pop && (pending == PW'(1)));
  assign a_merge   = first_vld && can_merge && (a_pc == tail_pc);
  assign b_merge_a = second_vld && (b_pc == a_pc);

  always_comb begin
    push_cnt     = 2'd0;
    push0_pc     = a_pc;
    push0_target = a_tgt;
    push1_pc     = b_pc;
    push1_target = b_tgt;
    tail_wr      = 1'b0;
    tail_target  = b_merge_a ? b_tgt : a_tgt;
    if (first_vld) begin
      if (a_merge) begin
        tail_wr = 1'b1;
        if (second_vld && !b_merge_a) begin
          push_cnt     = 2'd1;
          push0_pc     = b_pc;
          push0_target = b_tgt;
        end
      end else begin
        push_cnt     = 2'd1;
        push0_target = b_merge_a ? b_tgt : a_tgt;
        if (second_vld && !b_merge_a) push_cnt = 2'd2;
      end
    end
  end

  btbq_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_btbq_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush_q),
    .pop          (pop),
    .push_cnt     (push_cnt),
    .push0_pc     (push0_pc),
    .push0_target (push0_target),
    .push1_pc     (push1_pc),
    .push1_target (push1_target),
    .tail_wr      (tail_wr),
    .tail_target  (tail_target),
    .head_pc      (head_pc),
    .head_target  (head_target),
    .tail_pc      (tail_pc),
    .pending      (pending)
  );

  // Round-robin flips after every contended cycle; a flush leaves it alone.
  always_comb begin
    rr_next = rr_reg;
    if (br_valid && jmp_valid && !flush_q) rr_next = rr_flip(rr_reg);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_reg      <= RR_BR;
      upd_en_reg  <= 1'b0;
      upd_pc_reg  <= '0;
      upd_tgt_reg <= '0;
    end else begin
      rr_reg     <= rr_next;
      upd_en_reg <= pop;
      if (pop) begin
        upd_pc_reg  <= head_pc;
        upd_tgt_reg <= head_target;
      end
    end
  end

  assign btb_update_enable     = upd_en_reg;
  assign btb_is_branch_or_jump = upd_en_reg;
  assign btb_pc_update         = upd_pc_reg;
  assign btb_target_update     = upd_tgt_reg;

endmodule

// File: tb/tb_btb_update_sched.sv
// Directed bench for btb_update_sched: arbitration order, merging, hold,
// flush and asynchronous reset, with hand-computed expectations.
module tb_btb_update_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        br_valid = 1'b0;
  logic [31:0] br_pc = '0;
  logic [31:0] br_target = '0;
  logic        br_ready;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_pc = '0;
  logic [31:0] jmp_target = '0;
  logic        jmp_ready;
  logic        hold = 1'b0;
  logic        flush_q = 1'b0;
  logic        btb_update_enable;
  logic [31:0] btb_pc_update;
  logic [31:0] btb_target_update;
  logic        btb_is_branch_or_jump;
  logic [2:0]  pending;

  int vec_cnt = 0;
  int err_cnt = 0;

  btb_update_sched #(.XLEN(32), .DEPTH(4)) dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .br_valid              (br_valid),
    .br_pc                 (br_pc),
    .br_target             (br_target),
    .br_ready              (br_ready),
    .jmp_valid             (jmp_valid),
    .jmp_pc                (jmp_pc),
    .jmp_target            (jmp_target),
    .jmp_ready             (jmp_ready),
    .hold                  (hold),
    .flush_q               (flush_q),
    .btb_update_enable     (btb_update_enable),
    .btb_pc_update         (btb_pc_update),
    .btb_target_update     (btb_target_update),
    .btb_is_branch_or_jump (btb_is_branch_or_jump),
    .pending               (pending)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_br(input logic [31:0] pc, input logic [31:0] tgt);
    br_valid  = 1'b1;
    br_pc     = pc;
    br_target = tgt;
    step();
    br_valid  = 1'b0;
  endtask

  task automatic expect_strobe(input string tag, input logic [31:0] pc, input logic [31:0] tgt);
    check_vec({tag, "_en"}, {31'd0, btb_update_enable}, 32'd1);
    check_vec({tag, "_pc"}, btb_pc_update, pc);
    check_vec({tag, "_tgt"}, btb_target_update, tgt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // ---- 1: reset, single branch update
    #2 reset_n = 1'b0;
    repeat (3) step();
    check_vec("rst_pending", {29'd0, pending}, 32'd0);
    check_vec("rst_en", {31'd0, btb_update_enable}, 32'd0);
    check_vec("rst_isbj", {31'd0, btb_is_branch_or_jump}, 32'd0);
    check_vec("rst_pc", btb_pc_update, 32'd0);
    check_vec("rst_tgt", btb_target_update, 32'd0);
    reset_n = 1'b1;
    step();
    br_valid = 1'b1; br_pc = 32'h100; br_target = 32'h200;
    #1 check_vec("t1_br_ready", {31'd0, br_ready}, 32'd1);
    step();
    br_valid = 1'b0;
    check_vec("t1_pending1", {29'd0, pending}, 32'd1);
    check_vec("t1_no_strobe_yet", {31'd0, btb_update_enable}, 32'd0);
    step();
    expect_strobe("t1", 32'h100, 32'h200);
    check_vec("t1_isbj", {31'd0, btb_is_branch_or_jump}, 32'd1);
    check_vec("t1_pending0", {29'd0, pending}, 32'd0);
    step();
    check_vec("t1_strobe_drop", {31'd0, btb_update_enable}, 32'd0);
    check_vec("t1_pc_held", btb_pc_update, 32'h100);

    // ---- 2: both valid, br favoured first, then jmp favoured
    br_valid = 1'b1;  br_pc = 32'h100;  br_target = 32'h111;
    jmp_valid = 1'b1; jmp_pc = 32'h140; jmp_target = 32'h155;
    #1 check_vec("t2_both_ready", {30'd0, br_ready, jmp_ready}, 32'd3);
    step();
    br_valid = 1'b0; jmp_valid = 1'b0;
    check_vec("t2_pending2", {29'd0, pending}, 32'd2);
    step();
    expect_strobe("t2a", 32'h100, 32'h111);
    step();
    expect_strobe("t2b", 32'h140, 32'h155);
    step();
    check_vec("t2_idle", {31'd0, btb_update_enable}, 32'd0);
    br_valid = 1'b1;  br_pc = 32'h180;  br_target = 32'h1a0;
    jmp_valid = 1'b1; jmp_pc = 32'h1c0; jmp_target = 32'h1e0;
    step();
    br_valid = 1'b0; jmp_valid = 1'b0;
    step();
    expect_strobe("t2c", 32'h1c0, 32'h1e0);
    step();
    expect_strobe("t2d", 32'h180, 32'h1a0);
    step();

    // ---- 3: hold, fill to capacity, then drain in order
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_valid = 1'b1; br_pc = 32'h1000 + 32'(i) * 32'h10; br_target = 32'h2000 + 32'(i);
      #1 check_vec($sformatf("t3_ready%0d", i), {31'd0, br_ready}, (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    br_valid = 1'b0;
    check_vec("t3_pending4", {29'd0, pending}, 32'd4);
    check_vec("t3_no_strobe", {31'd0, btb_update_enable}, 32'd0);
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      expect_strobe($sformatf("t3_drain%0d", i), 32'h1000 + 32'(i) * 32'h10, 32'h2000 + 32'(i));
    end
    step();
    check_vec("t3_empty", {29'd0, pending}, 32'd0);

    // ---- 4: merge of back-to-back updates to the same pc
    hold = 1'b1;
    push_br(32'h300, 32'h400);
    push_br(32'h300, 32'h500);
    check_vec("t4_pending1", {29'd0, pending}, 32'd1);
    hold = 1'b0;
    step();
    expect_strobe("t4", 32'h300, 32'h500);
    step();
    check_vec("t4_single", {31'd0, btb_update_enable}, 32'd0);
    check_vec("t4_empty", {29'd0, pending}, 32'd0);

    // ---- 5: flush with a request pending
    hold = 1'b1;
    push_br(32'h500, 32'h600);
    push_br(32'h510, 32'h610);
    push_br(32'h520, 32'h620);
    check_vec("t5_pending3", {29'd0, pending}, 32'd3);
    br_valid = 1'b1; br_pc = 32'h530; br_target = 32'h630; flush_q = 1'b1;
    #1 check_vec("t5_ready_low", {31'd0, br_ready}, 32'd0);
    step();
    br_valid = 1'b0; flush_q = 1'b0; hold = 1'b0;
    check_vec("t5_pending0", {29'd0, pending}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("t5_no_strobe%0d", i), {31'd0, btb_update_enable}, 32'd0);
      step();
    end

    // ---- 6: async reset while the strobe is high
    push_br(32'h700, 32'h800);
    step();
    expect_strobe("t6_pre", 32'h700, 32'h800);
    #2 reset_n = 1'b0;
    #1 check_vec("t6_async_en", {31'd0, btb_update_enable}, 32'd0);
    check_vec("t6_async_pc", btb_pc_update, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_vec("t6_pending0", {29'd0, pending}, 32'd0);
    check_vec("t6_en0", {31'd0, btb_update_enable}, 32'd0);

    // ---- 7: same-cycle pair with equal pc merges, second-ordered target wins
    hold = 1'b1;
    br_valid = 1'b1;  br_pc = 32'h900;  br_target = 32'h901;
    jmp_valid = 1'b1; jmp_pc = 32'h900; jmp_target = 32'h902;
    step();
    br_valid = 1'b0; jmp_valid = 1'b0;
    check_vec("t7_pending1", {29'd0, pending}, 32'd1);
    hold = 1'b0;
    step();
    expect_strobe("t7", 32'h900, 32'h902);
    step();

    // ---- 8: one free slot goes to the favoured requester (jmp after t7)
    hold = 1'b1;
    push_br(32'ha00, 32'hb00);
    push_br(32'ha10, 32'hb10);
    push_br(32'ha20, 32'hb20);
    br_valid = 1'b1;  br_pc = 32'ha30;  br_target = 32'hb30;
    jmp_valid = 1'b1; jmp_pc = 32'ha40; jmp_target = 32'hb40;
    #1 check_vec("t8_readys", {30'd0, br_ready, jmp_ready}, 32'd1);
    step();
    br_valid = 1'b0; jmp_valid = 1'b0;
    check_vec("t8_pending4", {29'd0, pending}, 32'd4);
    hold = 1'b0;
    step(); expect_strobe("t8a", 32'ha00, 32'hb00);
    step(); expect_strobe("t8b", 32'ha10, 32'hb10);
    step(); expect_strobe("t8c", 32'ha20, 32'hb20);
    step(); expect_strobe("t8d", 32'ha40, 32'hb40);
    step();
    check_vec("t8_empty", {29'd0, pending}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
